// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the z0 data-memory arbiter: requester IDs, the
// arbiter state encoding and the round-robin successor helper.
// No ports; imported by rr_pick3 and mem_arbiter.

package mem_arbiter_pkg;

   // Requester IDs. They double as bit positions in the request and grant vectors.
   localparam logic [1:0] REQ_FETCH = 2'd0;
   localparam logic [1:0] REQ_LOAD  = 2'd1;
   localparam logic [1:0] REQ_STORE = 2'd2;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_BUSY = 2'b01,
      ARB_DONE = 2'b10
   } arb_state_t;

   // Next requester in the circular order fetch -> load -> store -> fetch.
   // The unused code 3 folds back to fetch so the picker can never stall on it.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx >= REQ_STORE) ? REQ_FETCH : idx + 2'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// rr_pick3
// Purely combinational three-way round-robin picker. The first requester
// after rr_last, in circular order, wins.
// Ports:
//   req           in  3  request vector, bit i = requester ID i
//   rr_last       in  2  ID of the previous winner
//   winner_onehot out 3  one-hot winner, all zero when nothing requests
//   winner_idx    out 2  winner ID, meaningful only when any is high
//   any           out 1  at least one request is present

module rr_pick3 (
   input  logic [2:0] req,
   input  logic [1:0] rr_last,
   output logic [2:0] winner_onehot,
   output logic [1:0] winner_idx,
   output logic       any
);
   import mem_arbiter_pkg::*;

   logic [1:0] cand0;
   logic [1:0] cand1;
   logic [1:0] cand2;
   logic [3:0] req_ext;

   // Candidates in priority order, starting just after the last winner.
   assign cand0 = rr_next(rr_last);
   assign cand1 = rr_next(cand0);
   assign cand2 = rr_next(cand1);

   // Padded so that every 2-bit index selects a defined bit.
   assign req_ext = {1'b0, req};

   always_comb begin
      winner_idx = cand0;
      if (req_ext[cand0]) begin
         winner_idx = cand0;
      end else if (req_ext[cand1]) begin
         winner_idx = cand1;
      end else if (req_ext[cand2]) begin
         winner_idx = cand2;
      end
   end

   assign any           = |req;
   assign winner_onehot = any ? (3'b001 << winner_idx) : 3'b000;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the z0 CPU's single data-memory port between instruction fetch,
// load and store. It picks a winner round-robin, latches its address, write
// data and direction, and runs one memory transaction. A watchdog aborts
// transactions the memory never finishes.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   fetch/load/store_req               level requests, held until finish/abort
//   fetch/load/store_addr, store_data  sampled only at grant
//   fetch/load/store_grant             one-hot, high for the whole transaction
//   rd_data                            mem_rdata passed straight through
//   fetch/load_valid                   mem_valid routed to the winner
//   fetch/load/store_finish            mem_finish routed to the winner
//   fetch/load/store_abort             one-cycle watchdog abort to the winner
//   mem_req, mem_we, mem_addr, mem_wdata  memory request side
//   mem_rdata, mem_valid, mem_finish      memory response side
// TIMEOUT is the number of BUSY cycles before an abort and must be at least 2.

module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic        load_req,
   input  logic        store_req,
   input  logic [15:0] fetch_addr,
   input  logic [15:0] load_addr,
   input  logic [15:0] store_addr,
   input  logic [15:0] store_data,
   output logic        fetch_grant,
   output logic        load_grant,
   output logic        store_grant,
   output logic [15:0] rd_data,
   output logic        fetch_valid,
   output logic        load_valid,
   output logic        fetch_finish,
   output logic        load_finish,
   output logic        store_finish,
   output logic        fetch_abort,
   output logic        load_abort,
   output logic        store_abort,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_valid,
   input  logic        mem_finish
);
   import mem_arbiter_pkg::*;

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [2:0]    grant_q;
   logic [1:0]    rr_last;
   logic [CW-1:0] wd_cnt;
   logic [15:0]   addr_q;
   logic [15:0]   wdata_q;
   logic          we_q;

   logic [2:0]    req_vec;
   logic [2:0]    pick_onehot;
   logic [1:0]    pick_idx;
   logic          pick_any;
   logic [15:0]   pick_addr;

   logic          busy;
   logic          timeout_hit;
   logic          abort_pulse;

   assign req_vec = {store_req, load_req, fetch_req};

   rr_pick3 u_pick (
      .req           (req_vec),
      .rr_last       (rr_last),
      .winner_onehot (pick_onehot),
      .winner_idx    (pick_idx),
      .any           (pick_any)
   );

   always_comb begin
      pick_addr = fetch_addr;
      case (pick_idx)
         REQ_LOAD:  pick_addr = load_addr;
         REQ_STORE: pick_addr = store_addr;
         default:   pick_addr = fetch_addr;
      endcase
   end

   assign busy        = (state == ARB_BUSY);
   assign timeout_hit = (wd_cnt == LAST_CNT);
   // A finish arriving on the last watchdog cycle wins over the abort.
   assign abort_pulse = busy && !mem_finish && timeout_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (mem_finish || timeout_hit) begin
               state_nxt = ARB_DONE;
            end
         end
         ARB_DONE: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   // Grant, latched transaction fields, round-robin pointer and watchdog.
   // The latched fields stay put after a transaction until the next grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_q <= 3'b000;
         rr_last <= REQ_STORE;
         wd_cnt  <= '0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         we_q    <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_q <= pick_onehot;
                  rr_last <= pick_idx;
                  wd_cnt  <= '0;
                  addr_q  <= pick_addr;
                  we_q    <= (pick_idx == REQ_STORE);
                  wdata_q <= (pick_idx == REQ_STORE) ? store_data : 16'h0000;
               end
            end
            ARB_BUSY: begin
               if (!timeout_hit) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: begin
               grant_q <= 3'b000;
            end
         endcase
      end
   end

   assign fetch_grant = grant_q[REQ_FETCH];
   assign load_grant  = grant_q[REQ_LOAD];
   assign store_grant = grant_q[REQ_STORE];

   assign mem_req   = busy;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rd_data   = mem_rdata;

   // Responses only reach the winner while the memory transaction is open;
   // the grant alone is not enough because it is still high during DONE.
   assign fetch_valid  = busy && mem_valid  && grant_q[REQ_FETCH];
   assign load_valid   = busy && mem_valid  && grant_q[REQ_LOAD];
   assign fetch_finish = busy && mem_finish && grant_q[REQ_FETCH];
   assign load_finish  = busy && mem_finish && grant_q[REQ_LOAD];
   assign store_finish = busy && mem_finish && grant_q[REQ_STORE];
   assign fetch_abort  = abort_pulse && grant_q[REQ_FETCH];
   assign load_abort   = abort_pulse && grant_q[REQ_LOAD];
   assign store_abort  = abort_pulse && grant_q[REQ_STORE];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of directed vectors, a few
// hand-written multi-cycle sequences, and a randomized run compared against
// a transaction-level reference model.

module tb_mem_arbiter;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req, load_req, store_req;
   logic [15:0] fetch_addr, load_addr, store_addr, store_data;
   logic        fetch_grant, load_grant, store_grant;
   logic [15:0] rd_data;
   logic        fetch_valid, load_valid;
   logic        fetch_finish, load_finish, store_finish;
   logic        fetch_abort, load_abort, store_abort;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_valid, mem_finish;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_req    (fetch_req),
      .load_req     (load_req),
      .store_req    (store_req),
      .fetch_addr   (fetch_addr),
      .load_addr    (load_addr),
      .store_addr   (store_addr),
      .store_data   (store_data),
      .fetch_grant  (fetch_grant),
      .load_grant   (load_grant),
      .store_grant  (store_grant),
      .rd_data      (rd_data),
      .fetch_valid  (fetch_valid),
      .load_valid   (load_valid),
      .fetch_finish (fetch_finish),
      .load_finish  (load_finish),
      .store_finish (store_finish),
      .fetch_abort  (fetch_abort),
      .load_abort   (load_abort),
      .store_abort  (store_abort),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_valid    (mem_valid),
      .mem_finish   (mem_finish)
   );

   // One directed cycle: inputs to drive and the outputs they must produce.
   typedef struct {
      logic [2:0]  req;
      logic        mv;
      logic        mf;
      logic [15:0] rdata;
      logic [12:0] exp_flags;
      logic [15:0] exp_addr;
   } vec_t;

   vec_t vecs[11];

   // Flag word layout: {grant[2:0], valid[1:0], finish[2:0], abort[2:0], mem_req, mem_we},
   // with bit i of each group belonging to requester ID i.
   function automatic logic [12:0] mk_flags(input logic [2:0] g, input logic [1:0] v,
                                            input logic [2:0] f, input logic [2:0] a,
                                            input logic r, input logic w);
      return {g, v, f, a, r, w};
   endfunction

   function logic [12:0] act_flags();
      return {store_grant, load_grant, fetch_grant, load_valid, fetch_valid,
              store_finish, load_finish, fetch_finish,
              store_abort, load_abort, fetch_abort, mem_req, mem_we};
   endfunction

   function automatic vec_t mk_vec(input logic [2:0] req, input logic mv, input logic mf,
                                   input logic [15:0] rdata, input logic [12:0] flags,
                                   input logic [15:0] addr);
      vec_t v;
      v.req       = req;
      v.mv        = mv;
      v.mf        = mf;
      v.rdata     = rdata;
      v.exp_flags = flags;
      v.exp_addr  = addr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] req, input logic mv, input logic mf,
                                input logic [15:0] rdata);
      fetch_req  = req[0];
      load_req   = req[1];
      store_req  = req[2];
      mem_valid  = mv;
      mem_finish = mf;
      mem_rdata  = rdata;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(3'b000, 1'b0, 1'b0, 16'h0000);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
   endtask

   task automatic timeoutFail(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: no grant seen, expected one within bound (t=%0t)", name, $time);
   endtask

   // Reference model state: who holds the grant, whether the memory
   // transaction is still open, and how many cycles it has been open.
   int          m_owner;
   bit          m_active;
   int          m_age;
   int          m_last;
   logic [15:0] m_addr, m_wdata;
   logic        m_we;

   function automatic void model_reset();
      m_owner  = -1;
      m_active = 1'b0;
      m_age    = 0;
      m_last   = 2;
      m_addr   = 16'h0000;
      m_wdata  = 16'h0000;
      m_we     = 1'b0;
   endfunction

   initial begin
      #1000000;
      $display("[TB] FAIL global_time_limit: simulation still running, expected it to finish");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      rst_n      = 1'b0;
      fetch_addr = 16'h1F00;
      load_addr  = 16'h0ABC;
      store_addr = 16'h0010;
      store_data = 16'h1234;
      applyStimulus(3'b000, 1'b0, 1'b0, 16'h0000);

      // Directed table: load with valid on cycle 3 and finish on cycle 4,
      // then a fetch; responses in DONE/IDLE must be ignored.
      vecs[0]  = mk_vec(3'b010, 1'b0, 1'b0, 16'h0000, mk_flags(3'b000, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0), 16'h0000);
      vecs[1]  = mk_vec(3'b010, 1'b0, 1'b0, 16'h0000, mk_flags(3'b010, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0), 16'h0ABC);
      vecs[2]  = mk_vec(3'b010, 1'b0, 1'b0, 16'h1111, mk_flags(3'b010, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0), 16'h0ABC);
      vecs[3]  = mk_vec(3'b010, 1'b1, 1'b0, 16'hBEEF, mk_flags(3'b010, 2'b10, 3'b000, 3'b000, 1'b1, 1'b0), 16'h0ABC);
      vecs[4]  = mk_vec(3'b010, 1'b0, 1'b1, 16'hBEEF, mk_flags(3'b010, 2'b00, 3'b010, 3'b000, 1'b1, 1'b0), 16'h0ABC);
      vecs[5]  = mk_vec(3'b000, 1'b1, 1'b1, 16'h2222, mk_flags(3'b010, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0), 16'h0ABC);
      vecs[6]  = mk_vec(3'b001, 1'b1, 1'b1, 16'h3333, mk_flags(3'b000, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0), 16'h0ABC);
      vecs[7]  = mk_vec(3'b001, 1'b1, 1'b0, 16'h4444, mk_flags(3'b001, 2'b01, 3'b000, 3'b000, 1'b1, 1'b0), 16'h1F00);
      vecs[8]  = mk_vec(3'b001, 1'b0, 1'b1, 16'h5555, mk_flags(3'b001, 2'b00, 3'b001, 3'b000, 1'b1, 1'b0), 16'h1F00);
      vecs[9]  = mk_vec(3'b000, 1'b0, 1'b0, 16'h0000, mk_flags(3'b001, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0), 16'h1F00);
      vecs[10] = mk_vec(3'b000, 1'b0, 1'b0, 16'h0000, mk_flags(3'b000, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0), 16'h1F00);

      doReset();
      #1;
      checkOutput("reset_flags", 16'(act_flags()), 16'h0000);
      checkOutput("reset_addr",  mem_addr,  16'h0000);
      checkOutput("reset_wdata", mem_wdata, 16'h0000);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].req, vecs[i].mv, vecs[i].mf, vecs[i].rdata);
         #1;
         checkOutput($sformatf("vec%0d_flags", i), 16'(act_flags()), 16'(vecs[i].exp_flags));
         checkOutput($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
         checkOutput($sformatf("vec%0d_wdata", i), mem_wdata, 16'h0000);
         checkOutput($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rdata);
         nextCycle();
      end

      // Everyone requesting continuously, memory finishing at once:
      // grants must rotate fetch, load, store, fetch, load, store.
      doReset();
      store_data = 16'h5A5A;
      applyStimulus(3'b111, 1'b0, 1'b1, 16'h0000);
      #1;
      for (int t = 0; t < 6; t++) begin
         int waited = 0;
         while (!(fetch_grant || load_grant || store_grant) && waited < 10) begin
            nextCycle();
            #1;
            waited++;
         end
         if (waited >= 10) begin
            timeoutFail($sformatf("rr_grant%0d", t));
         end else begin
            checkOutput($sformatf("rr_order%0d", t), 16'({store_grant, load_grant, fetch_grant}),
                        16'(3'b001 << (t % 3)));
            if (store_grant) begin
               checkOutput($sformatf("rr_store_we%0d", t), 16'(mem_we), 16'h0001);
               checkOutput($sformatf("rr_store_wdata%0d", t), mem_wdata, 16'h5A5A);
               checkOutput($sformatf("rr_store_addr%0d", t), mem_addr, 16'h0010);
            end
         end
         waited = 0;
         while ((fetch_grant || load_grant || store_grant) && waited < 10) begin
            nextCycle();
            #1;
            waited++;
         end
      end

      // Store data changing after grant must not disturb the latched write data.
      doReset();
      store_addr = 16'h0010;
      store_data = 16'h1234;
      applyStimulus(3'b100, 1'b0, 1'b0, 16'h0000);
      nextCycle();
      #1;
      checkOutput("st_grant", 16'(act_flags()), 16'(mk_flags(3'b100, 2'b00, 3'b000, 3'b000, 1'b1, 1'b1)));
      checkOutput("st_addr", mem_addr, 16'h0010);
      store_data = 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         #1;
         checkOutput($sformatf("st_hold%0d", k), mem_wdata, 16'h1234);
      end
      applyStimulus(3'b100, 1'b1, 1'b1, 16'h0000);
      #1;
      checkOutput("st_finish", 16'(act_flags()), 16'(mk_flags(3'b100, 2'b00, 3'b100, 3'b000, 1'b1, 1'b1)));
      nextCycle();
      applyStimulus(3'b000, 1'b0, 1'b0, 16'h0000);
      #1;
      checkOutput("st_done", 16'(act_flags()), 16'(mk_flags(3'b100, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1)));
      checkOutput("st_done_wdata", mem_wdata, 16'h1234);

      // Memory never finishes: exactly one fetch_abort, on the last watchdog cycle.
      doReset();
      applyStimulus(3'b001, 1'b0, 1'b0, 16'h0000);
      nextCycle();
      begin
         int aborts    = 0;
         int abort_age = -1;
         for (int age = 0; age < TIMEOUT; age++) begin
            #1;
            if (fetch_abort) begin
               aborts++;
               abort_age = age;
            end
            nextCycle();
         end
         applyStimulus(3'b000, 1'b0, 1'b0, 16'h0000);
         #1;
         checkOutput("wd_abort_count", 16'(aborts), 16'd1);
         checkOutput("wd_abort_cycle", 16'(abort_age), 16'(TIMEOUT - 1));
         checkOutput("wd_done", 16'(act_flags()), 16'(mk_flags(3'b001, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0)));
         nextCycle();
         #1;
         checkOutput("wd_idle", 16'(act_flags()), 16'h0000);
      end

      // Finish on the same cycle the watchdog would fire: finish wins, no abort.
      doReset();
      applyStimulus(3'b001, 1'b0, 1'b0, 16'h0000);
      nextCycle();
      for (int k = 0; k < TIMEOUT - 1; k++) begin
         nextCycle();
      end
      applyStimulus(3'b001, 1'b0, 1'b1, 16'h0000);
      #1;
      checkOutput("race_finish", 16'(act_flags()), 16'(mk_flags(3'b001, 2'b00, 3'b001, 3'b000, 1'b1, 1'b0)));
      nextCycle();
      applyStimulus(3'b000, 1'b0, 1'b0, 16'h0000);
      #1;
      checkOutput("race_done", 16'(act_flags()), 16'(mk_flags(3'b001, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0)));

      // Reset in the middle of a load: everything drops, fetch wins next.
      doReset();
      applyStimulus(3'b010, 1'b0, 1'b0, 16'h0000);
      nextCycle();
      nextCycle();
      rst_n = 1'b0;
      applyStimulus(3'b111, 1'b0, 1'b0, 16'h0000);
      #1;
      checkOutput("rst_busy", 16'(act_flags()), 16'(mk_flags(3'b010, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0)));
      nextCycle();
      rst_n = 1'b1;
      #1;
      checkOutput("rst_cleared", 16'(act_flags()), 16'h0000);
      nextCycle();
      #1;
      checkOutput("rst_fetch_wins", 16'(act_flags()), 16'(mk_flags(3'b001, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0)));

      // Randomized run against the reference model.
      doReset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [2:0]  r_req;
         logic        r_mv, r_mf;
         logic [2:0]  eg, ef, ea;
         logic [1:0]  ev;
         logic [15:0] addrs[3];
         r_req      = 3'($urandom_range(0, 7));
         r_mv       = ($urandom_range(0, 2) == 0);
         r_mf       = ($urandom_range(0, 5) == 0);
         fetch_addr = 16'($urandom);
         load_addr  = 16'($urandom);
         store_addr = 16'($urandom);
         store_data = 16'($urandom);
         rst_n      = ($urandom_range(0, 149) != 0);
         applyStimulus(r_req, r_mv, r_mf, 16'($urandom));
         #1;

         eg = 3'b000;
         ev = 2'b00;
         ef = 3'b000;
         ea = 3'b000;
         if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (m_active) begin
               if (r_mv && m_owner < 2) ev[m_owner] = 1'b1;
               if (r_mf) ef[m_owner] = 1'b1;
               if (!r_mf && m_age == TIMEOUT - 1) ea[m_owner] = 1'b1;
            end
         end
         checkOutput($sformatf("rnd%0d_flags", cyc), 16'(act_flags()),
                     16'(mk_flags(eg, ev, ef, ea, m_active, m_we)));
         checkOutput($sformatf("rnd%0d_addr", cyc), mem_addr, m_addr);
         checkOutput($sformatf("rnd%0d_wdata", cyc), mem_wdata, m_wdata);
         checkOutput($sformatf("rnd%0d_rd_data", cyc), rd_data, mem_rdata);

         addrs[0] = fetch_addr;
         addrs[1] = load_addr;
         addrs[2] = store_addr;
         if (!rst_n) begin
            model_reset();
         end else if (m_owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
               int c;
               c = (m_last + k) % 3;
               if (m_owner < 0 && r_req[c]) begin
                  m_owner  = c;
                  m_last   = c;
                  m_active = 1'b1;
                  m_age    = 0;
                  m_addr   = addrs[c];
                  m_we     = (c == 2);
                  m_wdata  = (c == 2) ? store_data : 16'h0000;
               end
            end
         end else if (m_active) begin
            if (r_mf || m_age == TIMEOUT - 1) begin
               m_active = 1'b0;
            end else begin
               m_age++;
            end
         end else begin
            m_owner = -1;
         end
         nextCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
